// File: rtl/amba_axi_pkg.sv
// Shared AXI write-channel constants and the burst FSM state type.
package amba_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int AXI_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_RESP
  } burst_st_e;

  function automatic int unsigned min3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

endpackage

// File: rtl/pcm_word_fifo.sv
// First-word-fall-through word FIFO: head is valid whenever count != 0.
module pcm_word_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array, no reset needed: reads are gated by count
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pcm_axi_burst_packer.sv
// Packs 16-bit PCM samples into 32-bit words and writes them as AXI bursts
// into a ring buffer, one burst in flight at a time.
module pcm_axi_burst_packer
  import amba_axi_pkg::*;
#(
  parameter int          wordLength  = 16,
  parameter int          BURST_BEATS = 16,
  parameter int          FIFO_DEPTH  = 32,
  parameter int          BUF_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [wordLength-1:0] in_sample,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [31:0]           cmd_addr,
  output logic [AXI_LEN_W-1:0]  cmd_len,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  output logic                  wr_last,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  input  logic                  resp_valid,
  input  logic [1:0]            resp_code,
  output logic                  resp_ready,
  output logic                  error,
  output logic                  frame_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(BUF_WORDS);

  burst_st_e       state;
  logic            half_valid;
  logic [15:0]     half_data;
  logic            flush_pending;
  logic [OW-1:0]   offset;
  logic [4:0]      beats_r;
  logic [4:0]      beat_cnt;

  logic            in_fire, push, pop;
  logic [35:0]     push_data, head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [OW:0]     room;
  logic [4:0]      launch_beats;
  logic            launch;

  // Reset gates in_ready so every output reads 0 while reset is held
  assign in_ready  = ~reset & ~fifo_full & ~flush_pending;
  assign in_fire   = in_valid & in_ready;
  assign push      = in_fire & (half_valid | in_last);
  assign push_data = half_valid ? {4'b1111, in_sample, half_data}
                                : {4'b0011, 16'h0000, in_sample};
  assign pop       = wr_valid & wr_ready;
  assign wr_data   = wr_valid ? head[31:0]  : 32'h0;
  assign wr_strb   = wr_valid ? head[35:32] : 4'h0;

  pcm_word_fifo #(
    .W     (36),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Launch decision: cap by available words, burst size and distance to ring end
  always_comb begin
    room         = (OW+1)'(BUF_WORDS) - {1'b0, offset};
    launch_beats = 5'(min3(32'(fifo_count), 32'(BURST_BEATS), 32'(room)));
    launch       = (fifo_count >= CW'(BURST_BEATS)) ||
                   (flush_pending && (fifo_count != '0));
  end

  // Pack register holds the low half until its partner sample arrives
  always_ff @(posedge clock) begin
    if (reset) begin
      half_valid <= 1'b0;
      half_data  <= 16'h0;
    end else if (in_fire) begin
      if (half_valid || in_last) begin
        half_valid <= 1'b0;
      end else begin
        half_valid <= 1'b1;
        half_data  <= in_sample;
      end
    end
  end

  // Burst FSM; beats are reserved at launch so DATA never stalls on an empty FIFO
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      cmd_valid     <= 1'b0;
      cmd_addr      <= 32'h0;
      cmd_len       <= '0;
      wr_valid      <= 1'b0;
      wr_last       <= 1'b0;
      resp_ready    <= 1'b0;
      error         <= 1'b0;
      frame_done    <= 1'b0;
      flush_pending <= 1'b0;
      offset        <= '0;
      beats_r       <= '0;
      beat_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (in_fire && in_last) flush_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (launch) begin
            beats_r   <= launch_beats;
            cmd_addr  <= BASE_ADDR + 32'({offset, 2'b00});
            cmd_len   <= AXI_LEN_W'(launch_beats - 5'd1);
            cmd_valid <= 1'b1;
            state     <= ST_CMD;
          end else if (flush_pending && fifo_empty && !half_valid) begin
            frame_done    <= 1'b1;
            flush_pending <= 1'b0;
          end
        end
        ST_CMD: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            wr_valid  <= 1'b1;
            wr_last   <= (beats_r == 5'd1);
            beat_cnt  <= '0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (wr_ready) begin
            if (wr_last) begin
              wr_valid   <= 1'b0;
              wr_last    <= 1'b0;
              resp_ready <= 1'b1;
              state      <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 5'd1;
              wr_last  <= (beat_cnt + 5'd2 == beats_r);
            end
          end
        end
        ST_RESP: begin
          if (resp_valid) begin
            resp_ready <= 1'b0;
            if (resp_code != AXI_RESP_OKAY) error <= 1'b1;
            offset <= offset + OW'(beats_r);
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_axi_burst_packer.sv
// Self-checking bench for pcm_axi_burst_packer: directed table, ring wrap,
// command stall, error response, mid-burst reset and randomized frames.
module tb_pcm_axi_burst_packer;

  localparam int          BW   = 256;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clock = 1'b0, reset = 1'b1;
  logic [15:0] in_sample = '0;
  logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_last, wr_valid, wr_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [1:0]  resp_code = 2'b00;
  logic        resp_ready, error, frame_done;

  pcm_axi_burst_packer dut (
    .clock(clock), .reset(reset),
    .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_last(wr_last), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .resp_valid(resp_valid), .resp_code(resp_code),
    .resp_ready(resp_ready), .error(error), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {logic [31:0] addr; logic [3:0] len;} cmd_t;
  typedef struct {logic [31:0] data; logic [3:0] strb; logic last;} beat_t;
  typedef struct {
    int n; bit last; int ncmd; logic [3:0] len0;
    logic [31:0] first_d; logic [31:0] last_d; logic [3:0] last_s; bit done;
  } vec_t;

  cmd_t        cmds[$];
  beat_t       beats[$];
  logic [35:0] exp_q[$];

  int pass_cnt = 0, total_cnt = 0;

  bit cmd_hold = 0, wr_block = 0, wr_rand = 0, err_next = 0, resp_pend = 0;
  int n_resp = 0, n_done = 0, resp_cyc = 0, done_cyc = 0, cmdv_cyc = -1;
  int wv_drop = 0, cmd_unstable = 0, done_wide = 0;

  // reference model state: pairing rule, ring position
  bit          m_half = 0;
  logic [15:0] m_hdata = '0;
  int          moff = 0, last_in_cyc = 0, n_acc = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  function automatic void model_push(input logic [15:0] s, input bit last);
    if (m_half) begin
      exp_q.push_back({4'hF, s, m_hdata});
      m_half = 0;
    end else if (last) begin
      exp_q.push_back({4'h3, 16'h0000, s});
    end else begin
      m_half  = 1;
      m_hdata = s;
    end
  endfunction

  // Bus responder and monitor: drives slave-side inputs at negedge, samples 1 ns later
  initial begin : bus
    bit   exp_wv, cmd_wait, prev_done;
    cmd_t held, c;
    beat_t b;
    exp_wv = 0; cmd_wait = 0; prev_done = 0; held = '0;
    forever begin
      @(negedge clock);
      cmd_ready  = !cmd_hold;
      wr_ready   = wr_block ? 1'b0 : (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      resp_valid = resp_pend;
      resp_code  = err_next ? 2'b10 : 2'b00;
      #1;
      if (reset) begin
        exp_wv = 0; cmd_wait = 0; prev_done = 0; resp_pend = 0;
        continue;
      end
      if (cmd_wait && (!cmd_valid || cmd_addr !== held.addr || cmd_len !== held.len))
        cmd_unstable++;
      if (exp_wv && !wr_valid) wv_drop++;
      if (cmd_valid && cmdv_cyc < 0) cmdv_cyc = cyc;
      if (frame_done) begin
        if (prev_done) done_wide++;
        n_done++;
        done_cyc = cyc;
      end
      prev_done = frame_done;
      cmd_wait  = cmd_valid && !cmd_ready;
      held.addr = cmd_addr;
      held.len  = cmd_len;
      if (cmd_valid && cmd_ready) begin
        c.addr = cmd_addr; c.len = cmd_len;
        cmds.push_back(c);
        exp_wv = 1;
      end
      if (wr_valid && wr_ready) begin
        b.data = wr_data; b.strb = wr_strb; b.last = wr_last;
        beats.push_back(b);
        if (wr_last) begin exp_wv = 0; resp_pend = 1; end
      end
      if (resp_valid && resp_ready) begin
        resp_pend = 0; n_resp++; resp_cyc = cyc; err_next = 0;
      end
    end
  end

  task automatic send(input logic [15:0] s, input bit last, input bit gaps, output bit ok);
    int g;
    ok = 0;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin @(negedge clock); in_valid = 1'b0; end
    end
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clock);
      in_valid = 1'b1; in_sample = s; in_last = last;
      #1;
      if (in_ready) begin
        ok = 1; model_push(s, last); last_in_cyc = cyc; n_acc++;
      end
    end
  endtask

  task automatic send_frame(input int n, input bit last, input bit rnd, input string nm);
    bit ok; int acc;
    logic [15:0] s;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      s = rnd ? 16'($urandom) : 16'(i + 1);
      send(s, last && (i == n - 1), rnd, ok);
      if (!ok) break;
      acc++;
    end
    check({nm, " samples accepted"}, acc, n);
    @(negedge clock);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 3000 && n_done < target; i++) @(negedge clock);
    #2;
    check({nm, " frame_done count"}, n_done, target);
  endtask

  task automatic wait_resp(input int target, input string nm);
    for (int i = 0; i < 3000 && n_resp < target; i++) @(negedge clock);
    #2;
    check({nm, " response count"}, n_resp, target);
  endtask

  // Consume recorded bursts: every beat must match the next packed word in order
  task automatic verify(input string nm);
    cmd_t c; beat_t b; logic [35:0] e; int nb;
    while (cmds.size() > 0) begin
      c  = cmds.pop_front();
      nb = int'(c.len) + 1;
      check({nm, " addr"}, c.addr, BASE + 32'(moff * 4));
      check({nm, " inside ring"}, (moff + nb <= BW), 1'b1);
      for (int i = 0; i < nb; i++) begin
        if (beats.size() == 0) begin
          check({nm, " missing beats"}, 0, nb - i);
          break;
        end
        b = beats.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 36'hx;
        check({nm, " data"}, b.data, e[31:0]);
        check({nm, " strb"}, b.strb, e[35:32]);
        check({nm, " last"}, b.last, (i == nb - 1));
      end
      moff = (moff + nb) % BW;
    end
    check({nm, " leftover beats"}, beats.size(), 0);
    check({nm, " leftover words"}, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    vec_t tv[4];
    int   r0, d0, a0, k;
    tv[0] = '{32, 1'b0, 1, 4'd15, 32'h0002_0001, 32'h0020_001F, 4'hF, 1'b0};
    tv[1] = '{7,  1'b1, 1, 4'd3,  32'h0002_0001, 32'h0000_0007, 4'h3, 1'b1};
    tv[2] = '{6,  1'b1, 1, 4'd2,  32'h0002_0001, 32'h0006_0005, 4'hF, 1'b1};
    tv[3] = '{1,  1'b1, 1, 4'd0,  32'h0000_0001, 32'h0000_0001, 4'h3, 1'b1};

    // reset state
    repeat (3) @(negedge clock);
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset cmd", {cmd_valid, cmd_addr, cmd_len}, 0);
    check("reset wr", {wr_valid, wr_last, wr_strb, wr_data}, 0);
    check("reset misc", {resp_ready, error, frame_done}, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock); #2;
    check("post-reset in_ready", in_ready, 1);

    // directed table
    for (int t = 0; t < 4; t++) begin
      r0 = n_resp; d0 = n_done; cmdv_cyc = -1;
      send_frame(tv[t].n, tv[t].last, 0, "table");
      if (tv[t].done) wait_done(d0 + 1, "table");
      else wait_resp(r0 + tv[t].ncmd, "table");
      repeat (4) @(negedge clock);
      #2;
      check("table burst count", cmds.size(), tv[t].ncmd);
      if (cmds.size() > 0) check("table cmd_len", cmds[0].len, tv[t].len0);
      if (beats.size() > 0) begin
        check("table first beat", beats[0].data, tv[t].first_d);
        check("table final beat", beats[$].data, tv[t].last_d);
        check("table final strb", beats[$].strb, tv[t].last_s);
        check("table final wr_last", beats[$].last, 1'b1);
      end
      check("table frame_done pulses", n_done - d0, tv[t].done);
      if (tv[t].done) check("table frame_done latency", done_cyc - resp_cyc, 2);
      else check("table cmd_valid latency", cmdv_cyc - last_in_cyc, 2);
      verify("table");
    end
    check("error clear", error, 0);

    // ring wrap: advance to offset 250, then 16 words split 6 + 10
    d0 = n_done;
    send_frame(452, 1, 0, "ring fill");
    wait_done(d0 + 1, "ring fill");
    verify("ring fill");
    send_frame(32, 1, 0, "ring wrap");
    wait_done(d0 + 2, "ring wrap");
    check("wrap burst count", cmds.size(), 2);
    if (cmds.size() == 2) begin
      check("wrap addr0", cmds[0].addr, BASE + 32'h3E8);
      check("wrap len0", cmds[0].len, 4'd5);
      check("wrap addr1", cmds[1].addr, BASE);
      check("wrap len1", cmds[1].len, 4'd9);
    end
    verify("ring wrap");

    // command stall: FIFO fills to 32 words and back-pressures input
    cmd_hold = 1; a0 = n_acc; d0 = n_done;
    fork
      send_frame(80, 1, 0, "stall");
      begin
        repeat (90) @(negedge clock);
        #2;
        check("stall in_ready low", in_ready, 0);
        check("stall accepted", n_acc - a0, 64);
        check("stall cmd_valid held", cmd_valid, 1);
        check("stall cmd stable", cmd_unstable, 0);
        cmd_hold = 0;
      end
    join
    wait_done(d0 + 1, "stall");
    verify("stall");

    // SLVERR response sets sticky error
    d0 = n_done; err_next = 1;
    send_frame(4, 1, 0, "err");
    wait_done(d0 + 1, "err");
    check("error set", error, 1);
    verify("err");
    send_frame(6, 1, 0, "err2");
    wait_done(d0 + 2, "err2");
    check("error sticky", error, 1);
    verify("err2");

    // reset in the middle of a data phase
    wr_block = 1;
    send_frame(40, 0, 0, "rst");
    k = 0;
    while (!wr_valid && k < 50) begin @(negedge clock); #1; k++; end
    check("rst burst in data", wr_valid, 1);
    @(negedge clock); reset = 1'b1;
    @(negedge clock); #2;
    check("rst in_ready", in_ready, 0);
    check("rst cmd", {cmd_valid, cmd_addr, cmd_len}, 0);
    check("rst wr", {wr_valid, wr_last, wr_strb, wr_data}, 0);
    check("rst misc", {resp_ready, error, frame_done}, 0);
    wr_block = 0;
    @(negedge clock); reset = 1'b0;
    cmds.delete(); beats.delete(); exp_q.delete();
    m_half = 0; moff = 0;
    repeat (2) @(negedge clock);

    // randomized frames with random gaps and wr_ready
    wr_rand = 1; wv_drop = 0;
    for (int f = 0; f < 6; f++) begin
      d0 = n_done;
      send_frame($urandom_range(1, 70), 1, 1, "rnd");
      wait_done(d0 + 1, "rnd");
      verify("rnd");
    end
    check("wr_valid no mid-burst drop", wv_drop, 0);
    check("cmd stable overall", cmd_unstable, 0);
    check("frame_done single cycle", done_wide, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
